// File: rtl/conv_pe_mac.sv
// ============================================================================
//  Module   : conv_pe_mac
//  Purpose  : Streaming convolution PE. It accumulates KERNEL_SIZE signed
//             feature x weight products, then rounds, rescales, adds bias and
//             saturates. The result is held in a one-entry valid/ready register.
//  Options  : define CONV_PE_RELU_EN to clamp negative results to zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_pe_mac #(
  parameter int DATA_W      = 16,
  parameter int FRAC_W      = 10,
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_W       = 2*DATA_W + $clog2(KERNEL_SIZE) + 1
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] input_featuremap,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] output_featuremap,
  output logic                     sat
);

  localparam int CNT_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int PROD_W = 2*DATA_W;
  localparam int SUM_W  = ACC_W + 1;

  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(KERNEL_SIZE - 1);
  localparam logic signed [SUM_W-1:0] HALF     = SUM_W'(1) << (FRAC_W - 1);
  localparam logic signed [SUM_W-1:0] MAX_V    = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V    = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_sat;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_last;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_total;
  logic signed [SUM_W-1:0]  w_total_ext;
  logic signed [SUM_W-1:0]  w_round_sum;
  logic signed [SUM_W-1:0]  w_shifted;
  logic signed [SUM_W-1:0]  w_bias_ext;
  logic signed [SUM_W-1:0]  w_biased;
  logic signed [DATA_W-1:0] w_clip;
  logic                     w_sat;
  logic signed [DATA_W-1:0] w_result;

  // Reset gating keeps in_ready low while n_reset is held, even with start high.
  assign w_in_ready = n_reset & start & ~(r_out_valid & ~out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_last     = (r_cnt == LAST_CNT);

  assign w_prod      = input_featuremap * weight;
  assign w_prod_ext  = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_total     = r_acc + w_prod_ext;
  assign w_total_ext = {w_total[ACC_W-1], w_total};
  assign w_round_sum = w_total_ext + HALF;
  assign w_shifted   = w_round_sum >>> FRAC_W;
  assign w_bias_ext  = {{(SUM_W-DATA_W){bias[DATA_W-1]}}, bias};
  assign w_biased    = w_shifted + w_bias_ext;

  always_comb begin
    w_sat  = 1'b0;
    w_clip = w_biased[DATA_W-1:0];
    if (w_biased > MAX_V) begin
      w_sat  = 1'b1;
      w_clip = MAX_V[DATA_W-1:0];
    end else if (w_biased < MIN_V) begin
      w_sat  = 1'b1;
      w_clip = MIN_V[DATA_W-1:0];
    end
  end

`ifdef CONV_PE_RELU_EN
  assign w_result = w_clip[DATA_W-1] ? '0 : w_clip;
`else
  assign w_result = w_clip;
`endif

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (!start) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_cnt <= '0;
          r_acc <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= w_total;
        end
      end

      // A final beat may reload the register on the same edge it drains.
      if (w_accept && w_last) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_sat       <= w_sat;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready          = w_in_ready;
  assign out_valid         = r_out_valid;
  assign output_featuremap = r_out_data;
  assign sat               = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_conv_pe_mac.sv
// Scoreboard bench for conv_pe_mac: default 16/10/9 instance plus an 8/4/1 instance.
`default_nettype none
`timescale 1ns/1ps

module tb_conv_pe_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               n_reset, start, in_valid, out_ready;
  logic signed [15:0] fmap, wgt, bias_i;
  logic               in_ready, out_valid, sat;
  logic signed [15:0] ofm;

  logic              start8, in_valid8, out_ready8;
  logic signed [7:0] f8, w8, b8;
  logic              in_ready8, out_valid8, sat8;
  logic signed [7:0] o8;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic signed [15:0] d;
    logic               s;
  } exp_t;
  exp_t q[$];

  conv_pe_mac dut (
    .clk(clk), .n_reset(n_reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .input_featuremap(fmap), .weight(wgt), .bias(bias_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_featuremap(ofm), .sat(sat)
  );

  conv_pe_mac #(.DATA_W(8), .FRAC_W(4), .KERNEL_SIZE(1)) dut8 (
    .clk(clk), .n_reset(n_reset), .start(start8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .input_featuremap(f8), .weight(w8), .bias(b8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .output_featuremap(o8), .sat(sat8)
  );

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic send(input logic signed [15:0] f, input logic signed [15:0] w,
                      input logic signed [15:0] b);
    int n;
    n        = 0;
    in_valid = 1'b1;
    fmap     = f;
    wgt      = w;
    bias_i   = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 for 200 cycles expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_ofm"},       ofm,       0);
    chk({tag, "_sat"},       sat,       0);
    chk({tag, "_in_ready"},  in_ready,  0);
  endtask

  // Monitor: every handshake on the output side is compared with the queue head.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (n_reset && out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d expected none", ofm);
        end else begin
          e = q.pop_front();
          chk("sb_data", ofm, e.d);
          chk("sb_sat",  sat, e.s);
        end
      end
    end
  end

  initial begin : main
    int n;
    n_reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmap = '0; wgt = '0; bias_i = '0;
    start8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    f8 = '0; w8 = '0; b8 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk);
    #1 n_reset = 1'b1;
    start = 1'b1;

    // Basic window: latency and single-cycle valid
    q.push_back('{16'sd9728, 1'b0});
    for (int i = 0; i < 9; i++) send(16'sd1024, 16'sd1024, 16'sd512);
    @(negedge clk);
    chk("basic_latency_valid", out_valid, 1);
    chk("basic_data", ofm, 9728);
    @(negedge clk);
    chk("basic_valid_one_cycle", out_valid, 0);
    idle(1);

    // Rounding half up at the FRAC_W boundary
    q.push_back('{16'sd1, 1'b0});
    send(16'sd1, 16'sd512, 16'sd0);
    for (int i = 0; i < 8; i++) send(16'sd0, 16'sd0, 16'sd0);
    q.push_back('{16'sd0, 1'b0});
    send(16'sd1, 16'sd511, 16'sd0);
    for (int i = 0; i < 8; i++) send(16'sd0, 16'sd0, 16'sd0);

    // Saturation at both rails
    q.push_back('{16'sd32767, 1'b1});
    for (int i = 0; i < 9; i++) send(16'sd32767, 16'sd32767, 16'sd0);
    q.push_back('{-16'sd32768, 1'b1});
    for (int i = 0; i < 9; i++) send(-16'sd32768, 16'sd32767, 16'sd0);
    idle(3);

    // Three back-to-back windows with a 5-cycle stall after the first result
    out_ready = 1'b0;
    q.push_back('{16'sd9216, 1'b0});
    q.push_back('{16'sd18432, 1'b0});
    q.push_back('{16'sd27648, 1'b0});
    fork
      begin
        for (int w = 1; w <= 3; w++)
          for (int i = 0; i < 9; i++) send(16'sd1024, 16'(1024 * w), 16'sd0);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("stream_first_valid", out_valid, 1);
        chk("stream_in_ready_drop", in_ready, 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(3);

    // Abort after 4 beats, then a clean window
    for (int i = 0; i < 4; i++) send(16'sd1024, 16'sd5000, 16'sd0);
    start = 1'b0;
    idle(1);
    start = 1'b1;
    q.push_back('{16'sd9728, 1'b0});
    for (int i = 0; i < 9; i++) send(16'sd1024, 16'sd1024, 16'sd512);
    idle(3);

    // Reset mid-window
    for (int i = 0; i < 4; i++) send(16'sd1024, 16'sd1024, 16'sd0);
    n_reset = 1'b0;
    #1 chk_zero_outputs("rst_mid_window");
    idle(1);
    n_reset = 1'b1;

    // Reset while a result is pending
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(16'sd1024, 16'sd1024, 16'sd512);
    @(negedge clk);
    chk("pending_valid", out_valid, 1);
    @(posedge clk);
    #1 n_reset = 1'b0;
    #1 chk_zero_outputs("rst_pending");
    idle(1);
    n_reset = 1'b1;
    out_ready = 1'b1;
    q.push_back('{16'sd9728, 1'b0});
    for (int i = 0; i < 9; i++) send(16'sd1024, 16'sd1024, 16'sd512);

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", q.size(), 0);
    idle(1);

    // Generic 8/4/1 build: one result per accepted beat
    start8 = 1'b1; f8 = 8'sd16; w8 = -8'sd16; b8 = 8'sd1; in_valid8 = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("g8_valid", out_valid8, 1);
      chk("g8_data",  o8, -15);
      chk("g8_sat",   sat8, 0);
    end
    @(posedge clk);
    #1 f8 = -8'sd128; w8 = -8'sd128; b8 = 8'sd0;
    @(posedge clk);
    @(negedge clk);
    chk("g8_sat_data", o8, 127);
    chk("g8_sat_flag", sat8, 1);
    #1 in_valid8 = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
